// File: rtl/yolo_layer_sequencer.sv
// Host-side ap_ctrl_hs initiator: walks a descriptor table, drives kernel arguments,
// and runs one start/done handshake per layer with a per-layer timeout.
module yolo_layer_sequencer #(
  parameter int MAX_LAYERS     = 16,
  parameter int DESC_W         = 96,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int AW             = $clog2(MAX_LAYERS)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_waddr,
  input  logic [DESC_W-1:0] tbl_wdata,
  input  logic              run_start,
  input  logic [AW:0]       num_layers,
  output logic              run_busy,
  output logic              run_done,
  output logic              run_err,
  output logic [AW:0]       cur_layer,
  output logic              k_ap_start,
  input  logic              k_ap_idle,
  input  logic              k_ap_done,
  input  logic              k_ap_ready,
  output logic [31:0]       k_img_width,
  output logic [31:0]       k_in_channels,
  output logic [31:0]       k_out_channels,
  output logic [31:0]       k_quant_M,
  output logic [31:0]       k_quant_n,
  output logic [31:0]       k_stride,
  output logic              k_is_maxpool,
  output logic              k_is_1x1
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0] MAXL = (AW+1)'(MAX_LAYERS);

  // Descriptor without the reserved nibble, which is never stored.
  typedef struct packed {
    logic [1:0]  stride;
    logic        is_1x1;
    logic        is_maxpool;
    logic [7:0]  quant_n;
    logic [31:0] quant_m;
    logic [15:0] out_ch;
    logic [15:0] in_ch;
    logic [15:0] img_w;
  } desc_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ARGS, S_WAIT_IDLE, S_START, S_WAIT_DONE, S_GAP, S_FINISH, S_ERROR
  } state_t;

  state_t          state;
  desc_t           tbl [MAX_LAYERS];
  desc_t           rd_q;
  logic [AW:0]     n_q;
  logic [AW:0]     nxt_layer;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            unused_rsvd;

  assign unused_rsvd = ^tbl_wdata[DESC_W-1:92];
  assign nxt_layer   = cur_layer + 1'b1;
  assign to_hit      = (to_cnt == TO_LAST);

  always_ff @(posedge ap_clk) begin
    if (tbl_we && !run_busy) tbl[tbl_waddr] <= desc_t'(tbl_wdata[91:0]);
    if (state == S_LOAD)     rd_q <= tbl[cur_layer[AW-1:0]];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state          <= S_IDLE;
      n_q            <= '0;
      to_cnt         <= '0;
      run_busy       <= 1'b0;
      run_done       <= 1'b0;
      run_err        <= 1'b0;
      cur_layer      <= '0;
      k_ap_start     <= 1'b0;
      k_img_width    <= '0;
      k_in_channels  <= '0;
      k_out_channels <= '0;
      k_quant_M      <= '0;
      k_quant_n      <= '0;
      k_stride       <= '0;
      k_is_maxpool   <= 1'b0;
      k_is_1x1       <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        S_IDLE: if (run_start) begin
          n_q       <= (num_layers > MAXL) ? MAXL : num_layers;
          cur_layer <= '0;
          run_err   <= 1'b0;
          run_busy  <= 1'b1;
          state     <= (num_layers == '0) ? S_FINISH : S_LOAD;
        end
        S_LOAD: state <= S_ARGS;
        S_ARGS: begin
          k_img_width    <= 32'(rd_q.img_w);
          k_in_channels  <= 32'(rd_q.in_ch);
          k_out_channels <= 32'(rd_q.out_ch);
          k_quant_M      <= rd_q.quant_m;
          k_quant_n      <= 32'(rd_q.quant_n);
          k_stride       <= 32'(rd_q.stride);
          k_is_maxpool   <= rd_q.is_maxpool;
          k_is_1x1       <= rd_q.is_1x1;
          state          <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: if (k_ap_idle) begin
          k_ap_start <= 1'b1;
          to_cnt     <= '0;
          state      <= S_START;
        end
        // Completion wins over a timeout landing on the same cycle.
        S_START: begin
          to_cnt <= to_cnt + 1'b1;
          if (k_ap_ready && k_ap_done) begin
            k_ap_start <= 1'b0;
            state      <= S_GAP;
          end else if (to_hit) begin
            k_ap_start <= 1'b0;
            run_err    <= 1'b1;
            run_busy   <= 1'b0;
            state      <= S_ERROR;
          end else if (k_ap_ready) begin
            k_ap_start <= 1'b0;
            state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          to_cnt <= to_cnt + 1'b1;
          if (k_ap_done) begin
            state <= S_GAP;
          end else if (to_hit) begin
            run_err  <= 1'b1;
            run_busy <= 1'b0;
            state    <= S_ERROR;
          end
        end
        // Start is low here, so the kernel always sees a fresh rising edge.
        S_GAP: begin
          cur_layer <= nxt_layer;
          state     <= (nxt_layer == n_q) ? S_FINISH : S_LOAD;
        end
        S_FINISH: begin
          run_done <= 1'b1;
          run_busy <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yolo_layer_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-layer arguments and per-run outcomes,
// a negedge monitor pops and compares on every k_ap_start rise and run end.
module tb_yolo_layer_sequencer;
  localparam int TO = 100;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_waddr = '0;
  logic [95:0] tbl_wdata = '0;
  logic        run_start = 1'b0;
  logic [4:0]  num_layers = '0;
  logic        run_busy, run_done, run_err, k_ap_start;
  logic [4:0]  cur_layer;
  logic        k_ap_idle = 1'b1, k_ap_done = 1'b0, k_ap_ready = 1'b0;
  logic [31:0] k_img_width, k_in_channels, k_out_channels, k_quant_M, k_quant_n, k_stride;
  logic        k_is_maxpool, k_is_1x1;

  yolo_layer_sequencer #(.MAX_LAYERS(16), .DESC_W(96), .TIMEOUT_CYCLES(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata), .run_start(run_start), .num_layers(num_layers),
    .run_busy(run_busy), .run_done(run_done), .run_err(run_err), .cur_layer(cur_layer),
    .k_ap_start(k_ap_start), .k_ap_idle(k_ap_idle), .k_ap_done(k_ap_done),
    .k_ap_ready(k_ap_ready), .k_img_width(k_img_width), .k_in_channels(k_in_channels),
    .k_out_channels(k_out_channels), .k_quant_M(k_quant_M), .k_quant_n(k_quant_n),
    .k_stride(k_stride), .k_is_maxpool(k_is_maxpool), .k_is_1x1(k_is_1x1));

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] w, ic, oc, m, qn, st;
    logic        mp, o1;
    int          hi;
  } args_t;
  typedef struct { bit err; int starts; int cur; } run_t;

  args_t exp_args[$];
  run_t  exp_runs[$];

  // Reference descriptor table: what a layer should see, by field.
  logic [15:0] m_w[16], m_ic[16], m_oc[16];
  logic [31:0] m_m[16];
  logic [7:0]  m_qn[16];
  logic        m_mp[16], m_o1[16];
  logic [1:0]  m_st[16];

  int n_chk = 0, n_pass = 0;
  int rdy_dly = 0, done_dly = 0;
  bit hang = 0;
  int run_ends = 0, ends_at_launch = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit outs_zero();
    return !(run_busy | run_done | run_err | (|cur_layer) | k_ap_start | (|k_img_width) |
             (|k_in_channels) | (|k_out_channels) | (|k_quant_M) | (|k_quant_n) |
             (|k_stride) | k_is_maxpool | k_is_1x1);
  endfunction

  // Kernel responder: ready rdy_dly cycles after start, done done_dly cycles after ready.
  initial begin
    int  kcnt = 0;
    bit  kact = 0;
    forever begin
      @(posedge ap_clk); #2;
      if (!ap_rst_n) begin
        kact = 0; k_ap_idle = 1; k_ap_ready = 0; k_ap_done = 0;
      end else begin
        k_ap_ready = 0; k_ap_done = 0;
        if (kact) kcnt++;
        else begin
          k_ap_idle = 1;
          if (k_ap_start) begin kact = 1; kcnt = 0; k_ap_idle = 0; end
        end
        if (kact) begin
          if (kcnt == rdy_dly) k_ap_ready = 1;
          if (!hang && kcnt == rdy_dly + done_dly) begin k_ap_done = 1; kact = 0; end
          if (hang && !run_busy) kact = 0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int mcyc = 0, t_rise = 0, hi_cnt = 0, exp_hi = 0, starts_in_run = 0;
    bit prev_start = 0, prev_err = 0, await_done = 0;
    args_t ea;
    run_t  er;
    forever begin
      @(negedge ap_clk);
      mcyc++;
      if (!ap_rst_n) begin
        prev_start = 0; prev_err = 0; await_done = 0; hi_cnt = 0; starts_in_run = 0;
      end else begin
        if (k_ap_start && !prev_start) begin
          starts_in_run++;
          chk(!await_done, "start_before_done", await_done, 0);
          t_rise = mcyc; hi_cnt = 0;
          if (exp_args.size() == 0) chk(0, "unexpected_start", 1, 0);
          else begin
            ea = exp_args.pop_front();
            exp_hi = ea.hi;
            chk(k_img_width == ea.w && k_in_channels == ea.ic && k_out_channels == ea.oc,
                "arg_dims", longint'({k_img_width[15:0], k_in_channels[15:0], k_out_channels[15:0]}),
                longint'({ea.w[15:0], ea.ic[15:0], ea.oc[15:0]}));
            chk(k_quant_M == ea.m && k_quant_n == ea.qn && k_stride == ea.st &&
                k_is_maxpool == ea.mp && k_is_1x1 == ea.o1, "arg_quant_flags",
                longint'({k_quant_M, k_quant_n[7:0], k_is_maxpool, k_is_1x1, k_stride[1:0]}),
                longint'({ea.m, ea.qn[7:0], ea.mp, ea.o1, ea.st[1:0]}));
          end
          await_done = 1;
        end
        if (k_ap_start) hi_cnt++;
        if (!k_ap_start && prev_start) chk(hi_cnt == exp_hi, "start_high_cycles", hi_cnt, exp_hi);
        if (await_done && k_ap_done) await_done = 0;
        if (run_done) begin
          if (exp_runs.size() == 0) chk(0, "unexpected_run_done", 1, 0);
          else begin
            er = exp_runs.pop_front();
            chk(!er.err, "run_done_vs_err", 1, 0);
            chk(starts_in_run == er.starts, "run_start_count", starts_in_run, er.starts);
            chk(cur_layer == er.cur[4:0], "final_cur_layer", cur_layer, er.cur);
          end
          starts_in_run = 0; run_ends++;
        end
        if (run_err && !prev_err) begin
          if (exp_runs.size() == 0) chk(0, "unexpected_run_err", 1, 0);
          else begin
            er = exp_runs.pop_front();
            chk(er.err, "run_err_vs_done", 1, 0);
            chk(starts_in_run == er.starts, "err_start_count", starts_in_run, er.starts);
            chk(mcyc - t_rise == TO, "timeout_cycles", mcyc - t_rise, TO);
            chk(!run_busy && !k_ap_start, "err_busy_start_low", {run_busy, k_ap_start}, 0);
          end
          starts_in_run = 0; await_done = 0; run_ends++;
        end
        prev_start = k_ap_start; prev_err = run_err;
      end
    end
  end

  task automatic wr_desc(input int a, input logic [15:0] w, ic, oc, input logic [31:0] m,
                         input logic [7:0] qn, input logic mp, o1, input logic [1:0] st,
                         input bit upd);
    @(negedge ap_clk);
    tbl_we = 1; tbl_waddr = a[3:0];
    tbl_wdata = {4'($urandom), st, o1, mp, qn, m, oc, ic, w};
    @(negedge ap_clk);
    tbl_we = 0;
    if (upd) begin
      m_w[a] = w; m_ic[a] = ic; m_oc[a] = oc; m_m[a] = m; m_qn[a] = qn;
      m_mp[a] = mp; m_o1[a] = o1; m_st[a] = st;
    end
  endtask

  task automatic rand_desc(input int a, input bit upd);
    wr_desc(a, 16'($urandom), 16'($urandom), 16'($urandom), $urandom, 8'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), upd);
  endtask

  function automatic args_t exp_for(input int i, input int hi);
    args_t e;
    e.w = {16'd0, m_w[i]}; e.ic = {16'd0, m_ic[i]}; e.oc = {16'd0, m_oc[i]};
    e.m = m_m[i]; e.qn = {24'd0, m_qn[i]}; e.st = {30'd0, m_st[i]};
    e.mp = m_mp[i]; e.o1 = m_o1[i]; e.hi = hi;
    return e;
  endfunction

  // Leaves the caller at the negedge of cycle 1 (run_start sampled at end of cycle 0).
  task automatic launch(input int nl, input int rdy, input int dn, input bit hng);
    int n = (nl > 16) ? 16 : nl;
    rdy_dly = rdy; done_dly = dn; hang = hng;
    if (hng) begin
      exp_args.push_back(exp_for(0, rdy + 1));
      exp_runs.push_back('{1'b1, 1, 0});
    end else begin
      for (int i = 0; i < n; i++) exp_args.push_back(exp_for(i, rdy + 1));
      exp_runs.push_back('{1'b0, n, n});
    end
    ends_at_launch = run_ends;
    @(negedge ap_clk); run_start = 1; num_layers = 5'(nl);
    @(negedge ap_clk); run_start = 0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (run_ends == ends_at_launch && k < 5000) begin @(posedge ap_clk); k++; end
    if (run_ends == ends_at_launch) chk(0, "run_end_wait_expired", k, 5000);
    repeat (3) @(negedge ap_clk);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge ap_clk);
    chk(outs_zero(), "outs_during_reset", k_ap_start, 0);
    ap_rst_n = 1;
    @(negedge ap_clk);
    chk(outs_zero(), "outs_after_reset", {run_busy, cur_layer}, 0);

    for (int i = 0; i < 16; i++) rand_desc(i, 1);
    wr_desc(1, 16'd208, 16'd16, 16'd32, $urandom, 8'($urandom), 1'b1, 1'b0, 2'd2, 1);

    // 3 layers, ready+done together 10 cycles after start; first start at cycle 4.
    launch(3, 10, 0, 0);
    @(negedge ap_clk);
    @(negedge ap_clk); chk(k_ap_start == 0, "start_not_before_cycle4", k_ap_start, 0);
    @(negedge ap_clk); chk(k_ap_start == 1, "start_at_cycle4", k_ap_start, 1);
    wait_end();

    // Split handshake: ready at +2, done 50 later.
    launch(2, 2, 50, 0); wait_end();

    // Empty run: done pulse two cycles after run_start, no kernel start.
    launch(0, 0, 0, 0);
    chk(run_done == 0, "n0_done_not_cycle1", run_done, 0);
    @(negedge ap_clk); chk(run_done == 1, "n0_done_cycle2", run_done, 1);
    wait_end();

    // Oversized request clamps to the table depth.
    launch(20, $urandom_range(0, 3), $urandom_range(0, 5), 0); wait_end();

    // Timeout, sticky error, cleared by the next run.
    launch(1, 1, 0, 1); wait_end();
    repeat (4) @(negedge ap_clk);
    chk(run_err == 1 && run_busy == 0, "err_sticky", {run_err, run_busy}, 2);
    launch(1, 0, 3, 0);
    chk(run_err == 0, "err_cleared_on_start", run_err, 0);
    wait_end();

    // Table write and run_start while busy are both dropped.
    launch(3, 3, 30, 0);
    repeat (6) @(negedge ap_clk);
    rand_desc(1, 0);
    @(negedge ap_clk); run_start = 1; num_layers = 5'd5;
    @(negedge ap_clk); run_start = 0;
    wait_end();
    rand_desc(1, 1);
    launch(2, 1, 2, 0); wait_end();

    // Reset while start is high.
    launch(2, 20, 5, 0);
    k = 0;
    while (!k_ap_start && k < 50) begin @(negedge ap_clk); k++; end
    chk(k_ap_start == 1, "reached_start_before_reset", k_ap_start, 1);
    #1 ap_rst_n = 0;
    #1 chk(k_ap_start == 0, "async_start_drop", k_ap_start, 0);
    exp_args.delete(); exp_runs.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1;
    @(negedge ap_clk);
    chk(outs_zero(), "outs_after_mid_reset", {run_busy, k_ap_start}, 0);
    launch(4, $urandom_range(0, 4), $urandom_range(0, 8), 0); wait_end();

    // Random runs over freshly randomised descriptors.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) rand_desc($urandom_range(0, 15), 1);
      launch($urandom_range(1, 16), $urandom_range(0, 4), $urandom_range(0, 8), 0);
      wait_end();
    end

    chk(exp_args.size() == 0, "args_queue_drained", exp_args.size(), 0);
    chk(exp_runs.size() == 0, "runs_queue_drained", exp_runs.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/yolo_layer_sequencer.md
Name: yolo_layer_sequencer

Overview:
- Host-side initiator of the accelerator's ap_ctrl_hs control interface: the opposite end of the compute kernel's ap_start/ap_done/ap_ready/ap_idle responder.
- Holds a table of per-layer descriptors and, per run, walks layers 0..N-1 in order. For each layer it drives the kernel's scalar arguments, issues ap_start, and waits for ap_done.
- Sits between the run-control logic and the kernel top. Replaces per-layer host kicks for a whole TinyYOLO network pass.

Parameters:
- MAX_LAYERS, 16, descriptor table depth; power of two; AW = log2(MAX_LAYERS).
- DESC_W, 96, descriptor width in bits; fixed packing below.
- TIMEOUT_CYCLES, 2**24, maximum cycles allowed from ap_start to ap_done before error.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- tbl_we  in  1  descriptor write strobe.
- tbl_waddr  in  AW  descriptor write index.
- tbl_wdata  in  DESC_W  descriptor fields: [15:0] img_width, [31:16] in_channels, [47:32] out_channels, [79:48] quant_M, [87:80] quant_n, [88] is_maxpool, [89] is_1x1, [91:90] stride, [95:92] reserved.
- run_start  in  1  single-cycle run request.
- num_layers  in  AW+1  layers in the run; sampled on the accepted run_start.
- run_busy  out  1  high from the accepted run_start until run_done or error.
- run_done  out  1  one-cycle pulse on successful completion.
- run_err  out  1  sticky timeout flag; cleared by the next accepted run_start.
- cur_layer  out  AW+1  index of the layer in progress.
- k_ap_start  out  1  kernel start.
- k_ap_idle, k_ap_done, k_ap_ready  in  1 each  kernel status.
- k_img_width, k_in_channels, k_out_channels, k_quant_M, k_quant_n, k_stride  out  32 each  zero-extended kernel arguments.
- k_is_maxpool, k_is_1x1  out  1 each  kernel flags.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Table contents are undefined after reset and are not cleared.
- Table: synchronous write when tbl_we=1 and run_busy=0. Writes while busy are dropped. Read is synchronous, 1-cycle latency.
- FSM states: IDLE, LOAD, ARGS, WAIT_IDLE, START, WAIT_DONE, GAP, FINISH, ERROR.
- IDLE:
  - run_start=1 → latch n = min(num_layers, MAX_LAYERS); set cur_layer=0; clear run_err; set run_busy=1.
  - If n=0, go to FINISH. Otherwise go to LOAD.
  - run_start while busy is ignored.
- LOAD: issue table read at cur_layer → ARGS.
- ARGS: register all k_* argument outputs from the read data → WAIT_IDLE. Arguments therefore change at least 1 cycle before k_ap_start rises.
- WAIT_IDLE: stay until k_ap_idle=1 → START.
- START:
  - k_ap_start=1, held high until k_ap_ready=1.
  - On the ready cycle, k_ap_start drops the next cycle.
  - If k_ap_done=1 in the same cycle as ready (the kernel asserts both together), go directly to GAP; otherwise go to WAIT_DONE.
- WAIT_DONE: k_ap_start=0; wait for k_ap_done=1 → GAP.
- GAP:
  - Guarantees k_ap_start is low for at least 1 cycle, because the kernel edge-detects start.
  - cur_layer+1; if cur_layer+1 == n go to FINISH, else go to LOAD.
- FINISH: run_done=1 for one cycle; run_busy=0 the next cycle → IDLE. cur_layer holds its final value.
- Timeout:
  - Counter clears on entering START and increments in START and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES → ERROR: k_ap_start=0, run_err=1, run_busy=0, then IDLE on the next cycle.
  - No run_done pulse on error. run_err stays high until the next accepted run_start.
- Arguments hold stable from ARGS through GAP. They are never changed while k_ap_start=1 or while the kernel is busy.
- k_ap_done outside START/WAIT_DONE is ignored.
- Reset asserted mid-run: immediate return to reset values; k_ap_start drops asynchronously.
- Cycle timing for the first layer: run_start seen at cycle 0 → LOAD at 1 → ARGS at 2 → args valid at 3. k_ap_start rises at cycle 4 at the earliest, when k_ap_idle=1 at cycle 3.
- Layer-to-layer gap: ap_done → next k_ap_start is at least 4 cycles (GAP, LOAD, ARGS, WAIT_IDLE).

Test Plan:
- 3-layer run: write descriptors 0..2 (layer1 img_width=208, in_ch=16, out_ch=32, stride=2, is_maxpool=1); kernel model answers ready+done 10 cycles after start → exactly 3 k_ap_start pulses, each followed by a ≥1-cycle low. k_img_width=208 and k_stride=2 during layer 1. run_done pulses once; cur_layer=3.
- Split handshake: kernel asserts ready 2 cycles after start and done 50 cycles later → k_ap_start is high for exactly 3 cycles; no next start before done.
- num_layers=0 → run_done 2 cycles after run_start; k_ap_start never rises. num_layers=20 with MAX_LAYERS=16 → exactly 16 starts.
- Timeout with TIMEOUT_CYCLES=100: kernel never asserts done → ERROR after 100 cycles; run_err=1, run_busy=0, no run_done. The next run_start clears run_err.
- Writes during busy: write tbl_waddr=1 while layer 0 is running → layer 1 uses the old descriptor. run_start while busy → ignored; single run_done.
- Assert ap_rst_n=0 mid-START → k_ap_start=0 immediately. After release: run_busy=0, outputs 0, and a new run executes correctly.
